fcc_label_store: RTL
====================

// Module: fcc_label_store
// PURPOSE
//  Parametrised point-label store for the FCC clustering pipeline: ROWS x COLS cells, each
//  holding a LABEL_W-bit cluster label and an is_ground bit. Serves NRD independent read
//  ports (centre + neighbour lookups), and adds a hardware clear sweep, bounds checking,
//  write-first bypass and a live ground-cell count.
// PARAMETERS
//  ROWS      30   grid rows
//  COLS      30   grid columns
//  ROW_W     8    row index width
//  COL_W     5    column index width
//  LABEL_W   16   label width
//  NRD       2    number of read ports (>=1)
//  CLR_LABEL 0    label written by clear sweep and returned on out-of-range reads
//  (local) DEPTH=ROWS*COLS, CNT_W=$clog2(DEPTH+1)
// PORTS
//  clk           in   1            clock, all logic on posedge
//  rst_n         in   1            synchronous active-low reset
//  clr_start     in   1            request clear sweep (ignored while clr_busy)
//  clr_busy      out  1            high for the whole sweep
//  clr_done      out  1            1-cycle pulse after the last cell is cleared
//  we            in   1            write strobe
//  wr_row        in   ROW_W        write row
//  wr_col        in   COL_W        write column
//  wr_label      in   LABEL_W      write label
//  wr_is_ground  in   1            write ground flag
//  wr_err        out  1            1-cycle pulse: previous write dropped (out of range or during clear)
//  rd_en         in   NRD          per-port read request
//  rd_row        in   NRD*ROW_W    packed rows, port p at [p*ROW_W +: ROW_W]
//  rd_col        in   NRD*COL_W    packed columns
//  rd_valid      out  NRD          per-port data valid
//  rd_label      out  NRD*LABEL_W  packed labels
//  rd_is_ground  out  NRD          per-port ground flag
//  rd_oob        out  NRD          per-port out-of-range flag (qualified by rd_valid)
//  ground_cnt    out  CNT_W        number of cells with is_ground=1
// BEHAVIOUR
//  - Address = row*COLS + col; in range iff row<ROWS and col<COLS.
//  - Reset (rst_n=0 at posedge): FSM->IDLE, all outputs 0, ground_cnt=0, ground bits 0.
//    Label RAM is not cleared by reset; contents undefined until a clear sweep completes.
//  - FSM IDLE/CLEAR. IDLE --clr_start--> CLEAR (ptr=0). CLEAR writes CLR_LABEL, ground=0 at
//    ptr, ptr++ each cycle; at ptr==DEPTH-1 -> IDLE, clr_done pulses the next cycle.
//    Sweep takes DEPTH cycles; clr_busy=1 from the cycle after clr_start through the last write.
//    ground_cnt forced to 0 on the first CLEAR cycle.
//  - Writes: accepted only in IDLE and in range; commit at posedge. Dropped writes leave
//    state untouched and raise wr_err the next cycle.
//  - Ground bits kept in a DEPTH-bit register vector; ground_cnt updated on accepted write:
//    +1 if old=0,new=1; -1 if old=1,new=0; else unchanged. Never wraps (0..DEPTH).
//  - Reads: latency 1. rd_valid[p] <= rd_en[p]. Disabled ports hold previous data.
//    Out-of-range: rd_oob=1, rd_label=CLR_LABEL, rd_is_ground=0.
//    Same-cycle accepted write to same address: read returns the new data (write-first).
//    Reads issued while FSM is CLEAR (or in the clr_start cycle) return CLR_LABEL, ground=0, oob
//    per range check.
//  - All NRD ports independent; identical addresses on several ports allowed.
//  - Reset mid-sweep aborts: IDLE, clr_busy=0, no clr_done; partially cleared RAM.
// TESTING
//  1 rst_n=0 2 cycles -> all outputs 0, ground_cnt=0; then clr_start -> clr_busy 900 cycles, clr_done
//    once, read (29,29) -> label 0, ground 0.
//  2 write (3,4) label 0x00AB ground 1; next cycle read port0 (3,4) -> rd_valid=1, 0x00AB, ground 1,
//    ground_cnt=1; rewrite ground 0 -> ground_cnt=0.
//  3 same-cycle write (7,7)=0x1234 and read (7,7) on port1 -> port1 returns 0x1234 next cycle.
//  4 write (30,0) and read (0,30) -> wr_err pulse, rd_oob=1, label CLR_LABEL; RAM/ground_cnt unchanged.
//  5 write during sweep -> wr_err, dropped; read during sweep -> CLR_LABEL; clr_start during busy
//    ignored (single clr_done).
//  6 rst_n=0 mid-sweep at ptr=100 -> clr_busy=0 next cycle, no clr_done; new clr_start restarts from 0.

Source files
------------

// File: rtl/fcc_label_store.sv
// Point-label store for the FCC clustering pipeline: label RAM plus ground-flag vector,
// NRD registered read ports with write-first bypass, clear sweep and live ground count.
module fcc_label_store #(
   parameter int ROWS = 30,
   parameter int COLS = 30,
   parameter int ROW_W = 8,
   parameter int COL_W = 5,
   parameter int LABEL_W = 16,
   parameter int NRD = 2,
   parameter logic [LABEL_W-1:0] CLR_LABEL = '0,
   localparam int DEPTH = ROWS * COLS,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr_start,
   output logic                   clr_busy,
   output logic                   clr_done,
   input  logic                   we,
   input  logic [ROW_W-1:0]       wr_row,
   input  logic [COL_W-1:0]       wr_col,
   input  logic [LABEL_W-1:0]     wr_label,
   input  logic                   wr_is_ground,
   output logic                   wr_err,
   input  logic [NRD-1:0]         rd_en,
   input  logic [NRD*ROW_W-1:0]   rd_row,
   input  logic [NRD*COL_W-1:0]   rd_col,
   output logic [NRD-1:0]         rd_valid,
   output logic [NRD*LABEL_W-1:0] rd_label,
   output logic [NRD-1:0]         rd_is_ground,
   output logic [NRD-1:0]         rd_oob,
   output logic [CNT_W-1:0]       ground_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   function automatic logic in_grid(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
      return (32'(r) < 32'(ROWS)) && (32'(c) < 32'(COLS));
   endfunction

   function automatic logic [AW-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                input logic [COL_W-1:0] c);
      return AW'(32'(r) * 32'(COLS) + 32'(c));
   endfunction

   state_t             state_q, state_d;
   logic [AW-1:0]      ptr_q, ptr_d;
   logic               clr_done_q, clr_done_d;
   logic               wr_err_q, wr_err_d;
   logic [DEPTH-1:0]   ground_q, ground_d;
   logic [CNT_W-1:0]   ground_cnt_q, ground_cnt_d;

   logic [LABEL_W-1:0] label_mem [DEPTH];
   logic               mem_we;
   logic [AW-1:0]      mem_addr;
   logic [LABEL_W-1:0] mem_wdata;

   logic               wr_in_range;
   logic [AW-1:0]      wr_addr;
   logic               wr_acc;
   logic               clearing;

   assign wr_in_range = in_grid(wr_row, wr_col);
   assign wr_addr     = cell_addr(wr_row, wr_col);
   assign wr_acc      = we && (state_q == ST_IDLE) && wr_in_range;
   // Reads in the clr_start cycle already see the cleared view.
   assign clearing    = (state_q == ST_CLEAR) || clr_start;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      clr_done_d   = 1'b0;
      wr_err_d     = we && !wr_acc;
      ground_d     = ground_q;
      ground_cnt_d = ground_cnt_q;
      mem_we       = 1'b0;
      mem_addr     = wr_addr;
      mem_wdata    = wr_label;
      case (state_q)
         ST_IDLE: begin
            if (clr_start) begin
               state_d = ST_CLEAR;
               ptr_d   = '0;
            end
            if (wr_acc) begin
               mem_we            = 1'b1;
               ground_d[wr_addr] = wr_is_ground;
               if (wr_is_ground && !ground_q[wr_addr] && ground_cnt_q != CNT_W'(DEPTH))
                  ground_cnt_d = ground_cnt_q + 1'b1;
               else if (!wr_is_ground && ground_q[wr_addr] && ground_cnt_q != '0)
                  ground_cnt_d = ground_cnt_q - 1'b1;
            end
         end
         ST_CLEAR: begin
            mem_we          = 1'b1;
            mem_addr        = ptr_q;
            mem_wdata       = CLR_LABEL;
            ground_d[ptr_q] = 1'b0;
            if (ptr_q == '0)
               ground_cnt_d = '0;
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d    = ST_IDLE;
               clr_done_d = 1'b1;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         clr_done_q   <= 1'b0;
         wr_err_q     <= 1'b0;
         ground_q     <= '0;
         ground_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         clr_done_q   <= clr_done_d;
         wr_err_q     <= wr_err_d;
         ground_q     <= ground_d;
         ground_cnt_q <= ground_cnt_d;
      end
   end

   // Label RAM has no reset; writes are held off while reset is asserted.
   always_ff @(posedge clk) begin
      if (mem_we && rst_n)
         label_mem[mem_addr] <= mem_wdata;
   end

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ROW_W-1:0]   row;
      logic [COL_W-1:0]   col;
      logic               in_range;
      logic [AW-1:0]      addr;
      logic               valid_q, valid_d;
      logic               use_mem_q, use_mem_d;
      logic [LABEL_W-1:0] alt_label_q, alt_label_d;
      logic               gnd_q, gnd_d;
      logic               oob_q, oob_d;
      logic [LABEL_W-1:0] mem_label_q;

      assign row      = rd_row[gi*ROW_W +: ROW_W];
      assign col      = rd_col[gi*COL_W +: COL_W];
      assign in_range = in_grid(row, col);
      assign addr     = cell_addr(row, col);

      // Either the RAM output register or a side register (bypass/clear value) is presented.
      always_comb begin
         valid_d     = rd_en[gi];
         use_mem_d   = use_mem_q;
         alt_label_d = alt_label_q;
         gnd_d       = gnd_q;
         oob_d       = oob_q;
         if (rd_en[gi]) begin
            use_mem_d   = 1'b0;
            alt_label_d = CLR_LABEL;
            gnd_d       = 1'b0;
            oob_d       = !in_range;
            if (in_range && !clearing) begin
               if (wr_acc && (wr_addr == addr)) begin
                  alt_label_d = wr_label;
                  gnd_d       = wr_is_ground;
               end else begin
                  use_mem_d = 1'b1;
                  gnd_d     = ground_q[addr];
               end
            end
         end
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            valid_q     <= 1'b0;
            use_mem_q   <= 1'b0;
            alt_label_q <= '0;
            gnd_q       <= 1'b0;
            oob_q       <= 1'b0;
         end else begin
            valid_q     <= valid_d;
            use_mem_q   <= use_mem_d;
            alt_label_q <= alt_label_d;
            gnd_q       <= gnd_d;
            oob_q       <= oob_d;
         end
      end

      always_ff @(posedge clk) begin
         if (rd_en[gi] && in_range)
            mem_label_q <= label_mem[addr];
      end

      assign rd_valid[gi]                     = valid_q;
      assign rd_label[gi*LABEL_W +: LABEL_W]  = use_mem_q ? mem_label_q : alt_label_q;
      assign rd_is_ground[gi]                 = gnd_q;
      assign rd_oob[gi]                       = oob_q;
   end

   assign clr_busy   = (state_q == ST_CLEAR);
   assign clr_done   = clr_done_q;
   assign wr_err     = wr_err_q;
   assign ground_cnt = ground_cnt_q;

endmodule
